// File: rtl/byte_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between NUM_REQ requesters,
// with optional ownership lock and tagged routing of fixed-latency read data.
module byte_mem_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_wr_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_rd_valid,
  output logic [7:0]                req_rd_data,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wr_data,
  input  logic [7:0]                mem_rd_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a requester raises rd/wr and holds rd/wr/addr/data stable until
  // req_ack is high in the same cycle; the access is accepted on that edge.
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  owner;
  logic              owner_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic              grant_any;
  logic              locked;
  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] ack;

  logic [READ_LATENCY:0] tag_valid;
  logic [IDX_W-1:0]      tag_idx [0:READ_LATENCY];

  assign active = req_rd | req_wr;
  assign locked = owner_valid && req_lock[owner];

  always_comb begin
    int j;
    j         = 0;
    ack       = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    if (!reset) begin
      if (locked) begin
        // The locked owner may idle; nobody else is served meanwhile.
        if (active[owner]) begin
          grant_any = 1'b1;
          grant_idx = owner;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = int'(rr_ptr) + k;
          if (j >= NUM_REQ) j = j - NUM_REQ;
          if (!grant_any && active[j]) begin
            grant_any = 1'b1;
            grant_idx = IDX_W'(j);
          end
        end
      end
      if (grant_any) ack[grant_idx] = 1'b1;
    end
  end

  assign req_ack  = ack;
  assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      owner        <= '0;
      owner_valid  <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      tag_valid    <= '0;
      req_rd_valid <= '0;
      req_rd_data  <= '0;
      for (int k = 0; k <= READ_LATENCY; k++) tag_idx[k] <= '0;
    end else begin
      // Read wins when a requester raises both rd and wr.
      mem_rd <= grant_any & req_rd[grant_idx];
      mem_wr <= grant_any & req_wr[grant_idx] & ~req_rd[grant_idx];
      if (grant_any) begin
        rr_ptr      <= next_ptr;
        owner       <= grant_idx;
        owner_valid <= req_lock[grant_idx];
        mem_addr    <= req_addr[grant_idx*ADDR_W +: ADDR_W];
        mem_wr_data <= req_wr_data[grant_idx*8 +: 8];
      end else if (owner_valid && !req_lock[owner]) begin
        owner_valid <= 1'b0;
      end

      // Stage k lines up with k cycles after the strobe; the last stage meets mem_rd_data.
      tag_valid  <= {tag_valid[READ_LATENCY-1:0], grant_any & req_rd[grant_idx]};
      tag_idx[0] <= grant_idx;
      for (int k = READ_LATENCY; k > 0; k--) tag_idx[k] <= tag_idx[k-1];

      req_rd_valid <= '0;
      if (tag_valid[READ_LATENCY]) begin
        req_rd_valid[tag_idx[READ_LATENCY]] <= 1'b1;
        req_rd_data                         <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Scoreboard bench for byte_mem_arbiter: memory model behind the port, expected read
// returns queued at ack time from a reference memory and compared on rd_valid.
module tb_byte_mem_arbiter;

  localparam int N   = 3;
  localparam int LAT = 2;
  localparam int AW  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_rd, req_wr, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_wr_data;
  logic [N-1:0]    req_ack, req_rd_valid;
  logic [7:0]      req_rd_data;
  logic            mem_rd, mem_wr;
  logic [AW-1:0]   mem_addr;
  logic [7:0]      mem_wr_data, mem_rd_data;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic [7:0] mem     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;

  byte_mem_arbiter #(.NUM_REQ(N), .READ_LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_rd(req_rd), .req_wr(req_wr), .req_lock(req_lock),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_ack(req_ack), .req_rd_valid(req_rd_valid), .req_rd_data(req_rd_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  function automatic logic [7:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // memory model: data of a strobe seen in cycle T is presented in cycle T+LAT
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] = mem_wr_data;
    d0 <= mem_rd ? mem_read(mem_addr) : 8'h00;
    d1 <= d0;
  end
  assign mem_rd_data = d1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: pop on rd_valid, flush on reset, push/update on ack
  always @(negedge clk) begin
    logic [9:0] e;
    if (req_rd_valid != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_unexpected", 32'(req_rd_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rd_valid_idx", 32'(req_rd_valid), 32'(3'b001 << e[9:8]));
        check_eq("rd_data", 32'(req_rd_data), 32'(e[7:0]));
      end
    end
    if (reset) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          if (req_rd[i]) exp_q.push_back({2'(i), ref_read(req_addr[i*AW +: AW])});
          else if (req_wr[i]) ref_mem[req_addr[i*AW +: AW]] = req_wr_data[i*8 +: 8];
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic lk,
                         input logic [31:0] a, input logic [7:0] d);
    req_rd[i]              = rd;
    req_wr[i]              = wr;
    req_lock[i]            = lk;
    req_addr[i*AW +: AW]   = a;
    req_wr_data[i*8 +: 8]  = d;
  endtask

  task automatic clr_req(input int i);
    set_req(i, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  task automatic drain(input string tag);
    repeat (6) tick();
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    req_rd = '0; req_wr = '0; req_lock = '0; req_addr = '0; req_wr_data = '0;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 8'h00);
    tick(); tick();
    #2;
    check_eq("rst_ack", 32'(req_ack), 0);
    check_eq("rst_mem_rd", 32'(mem_rd), 0);
    check_eq("rst_mem_wr", 32'(mem_wr), 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_rd_valid", 32'(req_rd_valid), 0);

    // 1: simultaneous read and write from reset
    tick();
    reset = 1'b0;
    set_req(1, 1'b0, 1'b1, 1'b0, 32'h20, 8'hA5);
    #2 check_eq("t1_ack0", 32'(req_ack), 32'h1);
    tick(); clr_req(0);
    #2 check_eq("t1_ack1", 32'(req_ack), 32'h2);
    check_eq("t1_mem_rd", 32'(mem_rd), 1);
    check_eq("t1_mem_wr0", 32'(mem_wr), 0);
    check_eq("t1_rd_addr", mem_addr, 32'h10);
    tick(); clr_req(1);
    #2 check_eq("t1_mem_wr", 32'(mem_wr), 1);
    check_eq("t1_mem_rd0", 32'(mem_rd), 0);
    check_eq("t1_wr_addr", mem_addr, 32'h20);
    check_eq("t1_wr_data", 32'(mem_wr_data), 32'hA5);
    tick();
    #2 check_eq("t1_early_valid", 32'(req_rd_valid), 0);
    tick();
    #2 check_eq("t1_rd_valid", 32'(req_rd_valid), 32'h1);
    check_eq("t1_rd_data", 32'(req_rd_data), 32'h4A);

    // 2: continuous reads from both requesters alternate
    for (int k = 0; k < 8; k++) begin
      tick();
      set_req(0, 1'b1, 1'b0, 1'b0, 32'h40 + 32'((k + 1) & ~1), 8'h00);
      set_req(1, 1'b1, 1'b0, 1'b0, 32'h80 + 32'(k | 1), 8'h00);
      #2 check_eq("t2_alt_ack", 32'(req_ack), 32'(1 << (k % 2)));
    end
    tick(); clr_req(0); clr_req(1);
    drain("t2_drain");

    // 3: locked 4-byte write burst with an idle locked cycle
    tick();
    set_req(0, 1'b0, 1'b1, 1'b1, 32'h100, 8'hD0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h200, 8'h00);
    #2 check_eq("t3_lock_ack", 32'(req_ack), 32'h1);
    for (int m = 1; m < 4; m++) begin
      tick();
      if (m == 3) begin
        req_wr[0] = 1'b0;
        #2 check_eq("t3_idle_locked", 32'(req_ack), 0);
        tick();
      end
      set_req(0, 1'b0, 1'b1, 1'b1, 32'h100 + 32'(m), 8'hD0 + 8'(m));
      #2 check_eq("t3_lock_ack", 32'(req_ack), 32'h1);
    end
    tick(); clr_req(0);
    #2 check_eq("t3_release", 32'(req_ack), 32'h2);
    tick(); clr_req(1);
    drain("t3_drain");
    for (int m = 0; m < 4; m++)
      check_eq("t3_mem_byte", 32'(mem_read(32'h100 + 32'(m))), 32'hD0 + 32'(m));

    // 4: pointer at 2 after req1's ack, only req0/req1 active -> wrap to 0
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h500, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h600, 8'h00);
    #2 check_eq("t4_wrap_ack0", 32'(req_ack), 32'h1);
    tick(); clr_req(0);
    #2 check_eq("t4_ack1", 32'(req_ack), 32'h2);
    tick(); clr_req(1);
    drain("t4_drain");

    // 5: reset kills an in-flight read and restarts the pointer
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h300, 8'h00);
    #2 check_eq("t5_ack0", 32'(req_ack), 32'h1);
    tick(); clr_req(0);
    #2 check_eq("t5_mem_rd", 32'(mem_rd), 1);
    check_eq("t5_addr", mem_addr, 32'h300);
    tick();
    reset = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h310, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h320, 8'h00);
    #2 check_eq("t5_ack_in_reset", 32'(req_ack), 0);
    tick();
    reset = 1'b0;
    #2 check_eq("t5_no_rd_strobe", 32'(mem_rd), 0);
    check_eq("t5_no_wr_strobe", 32'(mem_wr), 0);
    check_eq("t5_ptr_reset_ack", 32'(req_ack), 32'h1);
    tick(); clr_req(0);
    #2 check_eq("t5_killed_valid", 32'(req_rd_valid), 0);
    check_eq("t5_ack1", 32'(req_ack), 32'h2);
    tick(); clr_req(1);
    drain("t5_drain");

    // 6: rd and wr both high -> read only
    tick();
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h400, 8'h77);
    #2 check_eq("t6_ack", 32'(req_ack), 32'h2);
    tick(); clr_req(1);
    #2 check_eq("t6_mem_rd", 32'(mem_rd), 1);
    check_eq("t6_mem_wr", 32'(mem_wr), 0);
    check_eq("t6_addr", mem_addr, 32'h400);
    drain("t6_drain");
    check_eq("t6_no_write", 32'(mem.exists(32'h400)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
